hci_core_credit_fifo: RTL and testbench
=======================================

# hci_core_credit_fifo

Credit-based decoupling FIFO for one HCI core channel, placed between an accelerator streamer (`tcdm_slave`) and the interconnect (`tcdm_master`). Request and response FIFOs have independent depths. A reservation counter issues a request only when a response slot is guaranteed, so the master side accepts every `r_valid` unconditionally and needs no response holding register. Parameter WRITE_RSP selects whether writes return a response beat.

## Interface
- REQ_DEPTH, 8: request FIFO depth (≥2).
- RSP_DEPTH, 8: response FIFO depth (≥2). Also the maximum number of reserved response slots.
- DW, hci_package::DEFAULT_DW: data width.
- BW, hci_package::DEFAULT_BW: byte width; byte-enable width is DW/BW.
- AW, hci_package::DEFAULT_AW: address width.
- UW, hci_package::DEFAULT_UW: user width; 0 is legal, and then `user`/`r_user` are driven to '0.
- WRITE_RSP, 1: 1 = the memory returns `r_valid` for writes; 0 = only reads return `r_valid`.
- LATCH_FIFO, 0: passed to both FIFOs.
- CW, $clog2(RSP_DEPTH+1): derived width of the reservation counter (localparam).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear of both FIFOs, the counter and the error flag.
- flags_o  out  hci_core_credit_flags_t  {req_empty, req_full, rsp_empty, rsp_full, idle, err}.
- reserved_o  out  CW  current reservation count.
- tcdm_slave  hci_core_intf.slave  upstream port.
- tcdm_master  hci_core_intf.master  downstream port.

## Operation
- **Request path.** The request word is `{add, user, data, be, wen}`; the `user` field is omitted when UW=0.
  - Push on `tcdm_slave.req`; `tcdm_slave.gnt` = request FIFO ready.
- **Counted request.** A request is counted if WRITE_RSP=1, or if it is a read (`wen`=1).
- **Issue.** `tcdm_master.req` = request FIFO valid & (!counted | reserved < RSP_DEPTH).
  - The request FIFO pops on `tcdm_master.req & tcdm_master.gnt`.
  - `tcdm_master.boffs` = '0.
- **Response path.** `tcdm_master.lrdy` is tied to 1.
  - `{r_user, r_data}` is pushed into the response FIFO on `tcdm_master.r_valid`.
  - `tcdm_slave.r_valid` = response FIFO valid.
  - The response FIFO pops on `tcdm_slave.lrdy`.
- **Reservation counter.**
  - +1 on a counted issue handshake.
  - −1 on a slave-side pop (`r_valid & lrdy`).
  - Both in the same cycle: unchanged.
  - Saturates at 0 and RSP_DEPTH; it never wraps.
- **err (sticky).** Set on `tcdm_master.r_valid` while the response FIFO is full, or while reserved = 0.
  - Beat while the FIFO is full: the beat is dropped.
  - Beat while reserved = 0 and the FIFO is not full: the beat is stored.
  - err is cleared only by clear_i or reset.
- **idle** = req_empty & rsp_empty & reserved = 0.
- **clear_i.** Legal at any time. It zeroes the counter and discards contents.
  - A response from a request issued before the clear then sets err when it arrives.
  - Software must wait for idle before clearing if err is undesired.
- **Reset values.**
  - `tcdm_master.req`, `tcdm_slave.r_valid`, `tcdm_slave.gnt` = 0 during reset, then `gnt` = 1 from the first cycle after reset.
  - `reserved_o` = 0.
  - flags_o = {1,0,1,0,1,0}.
  - Reset mid-operation discards everything asynchronously.

## Timing
- Request latency: a slave handshake in cycle N can issue on master at N+1 at the earliest.
- Response latency: master `r_valid` in cycle N gives slave `r_valid` at N+1 at the earliest.
- **Throughput.**
  - One request/cycle in steady state when RSP_DEPTH covers memory latency+1.
  - With the counter at RSP_DEPTH, issue resumes in the cycle after a slave pop.
- **Request FIFO full.** `gnt`=0. A simultaneous pop does not re-enable `gnt` in the same cycle (no fall-through).
- `tcdm_master.req` must not depend combinationally on `tcdm_master.gnt`.

## Structure
- hci_package gains:
  - `hci_core_credit_flags_t` (packed struct, fields as in flags_o).
  - A localparam helper for the counter width.
- Both FIFOs are existing hwpe_stream_fifo instances, wrapped through hwpe_stream_intf_stream.
- The one natural new sub-module is `hci_core_credit_counter`.
  - Parameters: MAX, CW.
  - Ports: `inc_i`, `dec_i`, `clear_i`, `count_o`, `avail_o`.
  - Reusable by future multi-channel variants.

## Test plan
1. **Read streaming, RSP_DEPTH=4, memory latency 1, slave `lrdy`=1, 16 reads.**
   - 16 responses in order.
   - `reserved_o` ≤2.
   - One issue per cycle after the first.
2. **Slave `lrdy`=0, 10 reads, RSP_DEPTH=4.**
   - Exactly 4 master issues, then `tcdm_master.req`=0.
   - `reserved_o`=4.
   - On `lrdy`=1, one additional issue per pop; all 10 data returned in order.
3. **WRITE_RSP=0, 8 writes with `lrdy`=0.** All 8 issue; `reserved_o` stays 0; no `r_valid` appears.
4. **Same-cycle counted issue and slave pop with reserved=3.** `reserved_o` remains 3.
5. **clear_i with 2 reads in flight.**
   - FIFOs empty and `reserved_o`=0 next cycle.
   - Late `r_valid` sets err=1.
   - err stays 1 until the next clear_i.
6. **Reset mid-burst (rst_ni low 1 cycle during a 6-read burst).** All outputs return to reset values immediately; post-reset traffic completes normally.

Source files
------------

// File: rtl/hci_core_credit_fifo_pkg.sv
// Shared types and helpers for the credit-based HCI core FIFO.
// Provides default widths, the status flag bundle and the counter width helper.
package hci_core_credit_fifo_pkg;

    localparam int unsigned DEFAULT_DW = 32;
    localparam int unsigned DEFAULT_BW = 8;
    localparam int unsigned DEFAULT_AW = 32;
    localparam int unsigned DEFAULT_UW = 2;

    typedef struct packed {
        logic req_empty;
        logic req_full;
        logic rsp_empty;
        logic rsp_full;
        logic idle;
        logic err;
    } hci_core_credit_flags_t;

    // Width needed to hold 0..depth inclusive.
    function automatic int unsigned credit_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hci_core_credit_fifo_if.sv
// HCI core channel bundle: request (req/gnt) and response (r_valid/lrdy).
// master drives requests and lrdy; slave drives gnt and response beats.
interface hci_core_credit_fifo_if
    import hci_core_credit_fifo_pkg::*;
#(
    parameter int unsigned DW = DEFAULT_DW,
    parameter int unsigned BW = DEFAULT_BW,
    parameter int unsigned AW = DEFAULT_AW,
    parameter int unsigned UW = DEFAULT_UW
);
    localparam int unsigned BEW = DW / BW;
    localparam int unsigned UWP = (UW > 0) ? UW : 1;

    logic           req;
    logic           gnt;
    logic [AW-1:0]  add;
    logic           wen;
    logic [DW-1:0]  data;
    logic [BEW-1:0] be;
    logic [BEW-1:0] boffs;
    logic [UWP-1:0] user;
    logic           lrdy;
    logic           r_valid;
    logic [DW-1:0]  r_data;
    logic [UWP-1:0] r_user;

    modport master (
        output req, add, wen, data, be, boffs, user, lrdy,
        input  gnt, r_valid, r_data, r_user
    );

    modport slave (
        input  req, add, wen, data, be, boffs, user, lrdy,
        output gnt, r_valid, r_data, r_user
    );

endinterface

// File: rtl/hci_core_credit_counter.sv
// Saturating reservation counter for response-slot credits.
// Ports: clk_i, rst_ni, clear_i, inc_i, dec_i, count_o, avail_o (count < MAX).
module hci_core_credit_counter #(
    parameter int unsigned MAX = 8,
    parameter int unsigned CW  = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          avail_o
);
    localparam logic [CW-1:0] MAXC = CW'(MAX);

    logic [CW-1:0] r_cnt;

    assign count_o = r_cnt;
    assign avail_o = (r_cnt < MAXC);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (inc_i && !dec_i && r_cnt != MAXC) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (dec_i && !inc_i && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/hci_core_credit_fifo_buf.sv
// Circular-buffer FIFO, no fall-through: ready depends only on stored count.
// Ports: clk_i, rst_ni, clear_i, push_i/data_i/ready_o, pop_i/data_o/valid_o, empty_o, full_o.
module hci_core_credit_fifo_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
    localparam logic [NW-1:0] FULLN = NW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [NW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign full_o  = (r_cnt == FULLN);
    assign empty_o = (r_cnt == '0);
    assign ready_o = ~full_o;
    assign valid_o = ~empty_o;
    assign data_o  = r_mem[r_rptr];

    // A push into a full buffer is dropped even if a pop happens alongside.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push)
                r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + NW'(1);
                2'b01:   r_cnt <= r_cnt - NW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/hci_core_credit_fifo.sv
// Credit-based decoupling FIFO between a streamer (tcdm_slave) and the interconnect (tcdm_master).
// Ports: clk_i, rst_ni, clear_i, flags_o, reserved_o, tcdm_slave, tcdm_master.
module hci_core_credit_fifo
    import hci_core_credit_fifo_pkg::*;
#(
    parameter int unsigned REQ_DEPTH  = 8,
    parameter int unsigned RSP_DEPTH  = 8,
    parameter int unsigned DW         = DEFAULT_DW,
    parameter int unsigned BW         = DEFAULT_BW,
    parameter int unsigned AW         = DEFAULT_AW,
    parameter int unsigned UW         = DEFAULT_UW,
    parameter int unsigned WRITE_RSP  = 1,
    parameter int unsigned LATCH_FIFO = 0,
    localparam int unsigned CW        = credit_cw(RSP_DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    output hci_core_credit_flags_t flags_o,
    output logic [CW-1:0]          reserved_o,
    hci_core_credit_fifo_if.slave  tcdm_slave,
    hci_core_credit_fifo_if.master tcdm_master
);
    localparam int unsigned BEW = DW / BW;
    localparam int unsigned RQW = AW + UW + DW + BEW + 1;
    localparam int unsigned RSW = UW + DW;

    logic           r_init;
    logic           r_err;
    logic [RQW-1:0] w_rq_in;
    logic [RQW-1:0] w_rq_out;
    logic           w_rq_push;
    logic           w_rq_ready;
    logic           w_rq_valid;
    logic           w_rq_empty;
    logic           w_rq_full;
    logic [RSW-1:0] w_rs_in;
    logic [RSW-1:0] w_rs_out;
    logic           w_rs_valid;
    logic           w_rs_empty;
    logic           w_rs_full;
    logic           w_rs_ready_unused;
    logic           w_counted;
    logic           w_avail;
    logic           w_issue;
    logic           w_rsp_pop;
    logic [CW-1:0]  w_cnt;
    logic           w_unused;

    assign w_unused = ^{tcdm_slave.boffs, (LATCH_FIFO != 0)};

    // Holds gnt low while in reset and releases it on the first clock after.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_init <= 1'b0;
        else
            r_init <= 1'b1;
    end

    generate
        if (UW > 0) begin : g_user
            assign w_rq_in = {tcdm_slave.add, tcdm_slave.user,
                              tcdm_slave.data, tcdm_slave.be,
                              tcdm_slave.wen};
            assign {tcdm_master.add, tcdm_master.user,
                    tcdm_master.data, tcdm_master.be,
                    tcdm_master.wen} = w_rq_out;
            assign w_rs_in = {tcdm_master.r_user, tcdm_master.r_data};
            assign {tcdm_slave.r_user, tcdm_slave.r_data} = w_rs_out;
        end else begin : g_nouser
            logic w_unused_user;
            assign w_unused_user = ^{tcdm_slave.user, tcdm_master.r_user};
            assign w_rq_in = {tcdm_slave.add, tcdm_slave.data,
                              tcdm_slave.be, tcdm_slave.wen};
            assign {tcdm_master.add, tcdm_master.data,
                    tcdm_master.be, tcdm_master.wen} = w_rq_out;
            assign tcdm_master.user = '0;
            assign w_rs_in = tcdm_master.r_data;
            assign tcdm_slave.r_data = w_rs_out;
            assign tcdm_slave.r_user = '0;
        end
    endgenerate

    assign tcdm_slave.gnt = w_rq_ready & r_init;
    assign w_rq_push      = tcdm_slave.req & tcdm_slave.gnt;

    // Only requests that will produce a response consume a credit.
    assign w_counted = (WRITE_RSP != 0) || w_rq_out[0];

    // Issue is gated only by registered state, never by gnt.
    assign tcdm_master.req   = w_rq_valid & (~w_counted | w_avail);
    assign w_issue           = tcdm_master.req & tcdm_master.gnt;
    assign tcdm_master.boffs = '0;
    assign tcdm_master.lrdy  = 1'b1;

    assign tcdm_slave.r_valid = w_rs_valid;
    assign w_rsp_pop          = w_rs_valid & tcdm_slave.lrdy;

    hci_core_credit_fifo_buf #(
        .DEPTH (REQ_DEPTH),
        .W     (RQW)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (w_rq_push),
        .data_i  (w_rq_in),
        .ready_o (w_rq_ready),
        .pop_i   (w_issue),
        .data_o  (w_rq_out),
        .valid_o (w_rq_valid),
        .empty_o (w_rq_empty),
        .full_o  (w_rq_full)
    );

    hci_core_credit_fifo_buf #(
        .DEPTH (RSP_DEPTH),
        .W     (RSW)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (tcdm_master.r_valid),
        .data_i  (w_rs_in),
        .ready_o (w_rs_ready_unused),
        .pop_i   (w_rsp_pop),
        .data_o  (w_rs_out),
        .valid_o (w_rs_valid),
        .empty_o (w_rs_empty),
        .full_o  (w_rs_full)
    );

    hci_core_credit_counter #(
        .MAX (RSP_DEPTH),
        .CW  (CW)
    ) i_credit (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .inc_i   (w_issue & w_counted),
        .dec_i   (w_rsp_pop),
        .count_o (w_cnt),
        .avail_o (w_avail)
    );

    // A beat with no slot or no outstanding credit means the credit
    // bookkeeping was violated (e.g. a clear with requests in flight).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_err <= 1'b0;
        else if (clear_i)
            r_err <= 1'b0;
        else if (tcdm_master.r_valid && (w_rs_full || w_cnt == '0))
            r_err <= 1'b1;
    end

    assign reserved_o        = w_cnt;
    assign flags_o.req_empty = w_rq_empty;
    assign flags_o.req_full  = w_rq_full;
    assign flags_o.rsp_empty = w_rs_empty;
    assign flags_o.rsp_full  = w_rs_full;
    assign flags_o.idle      = w_rq_empty & w_rs_empty & (w_cnt == '0);
    assign flags_o.err       = r_err;

endmodule

// File: tb/tb_hci_core_credit_fifo.sv
// Bench for hci_core_credit_fifo: RSP_DEPTH=4, WRITE_RSP=0, memory model with
// configurable latency, scoreboard of expected response beats.
module tb_hci_core_credit_fifo;
    import hci_core_credit_fifo_pkg::*;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b0;
    logic clear_i = 1'b0;
    hci_core_credit_flags_t flags;
    logic [2:0] reserved;

    hci_core_credit_fifo_if #(.DW(32), .BW(8), .AW(32), .UW(2)) s_if ();
    hci_core_credit_fifo_if #(.DW(32), .BW(8), .AW(32), .UW(2)) m_if ();

    hci_core_credit_fifo #(
        .REQ_DEPTH  (8),
        .RSP_DEPTH  (4),
        .DW         (32),
        .BW         (8),
        .AW         (32),
        .UW         (2),
        .WRITE_RSP  (0),
        .LATCH_FIFO (0)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .flags_o     (flags),
        .reserved_o  (reserved),
        .tcdm_slave  (s_if.slave),
        .tcdm_master (m_if.master)
    );

    always #5 clk_i = ~clk_i;

    assign m_if.gnt = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, n_pop = 0, n_hs = 0, n_iss = 0, n_mrv = 0;
    int first_iss = -1, last_iss = -1, rmax = 0;
    int drv_left = 0;
    int mem_lat = 1;
    logic [31:0] drv_addr = '0;
    logic        drv_wen  = 1'b1;
    logic [63:0] exp_q[$];

    function automatic logic [31:0] mdat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory: read responses after mem_lat cycles, writes silent.
    typedef struct {
        int          due;
        logic [31:0] a;
        logic [1:0]  u;
    } mreq_t;
    mreq_t mq[$];
    int mcyc = 0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
            m_if.r_valid <= 1'b0;
            m_if.r_data  <= '0;
            m_if.r_user  <= '0;
        end else begin
            mcyc = mcyc + 1;
            if (m_if.req && m_if.gnt && m_if.wen)
                mq.push_back('{mcyc + mem_lat - 1, m_if.add, m_if.user});
            if (mq.size() > 0 && mq[0].due <= mcyc) begin
                m_if.r_valid <= 1'b1;
                m_if.r_data  <= mdat(mq[0].a);
                m_if.r_user  <= mq[0].u;
                void'(mq.pop_front());
            end else begin
                m_if.r_valid <= 1'b0;
            end
        end
    end

    task automatic start(input int n, input logic [31:0] a, input logic w);
        drv_left  = n;
        drv_addr  = a;
        drv_wen   = w;
        s_if.req  = (n > 0);
        s_if.add  = a;
        s_if.wen  = w;
        s_if.data = ~a;
        s_if.user = a[3:2];
    endtask

    // One cycle: sample at negedge, then drive #1 after the posedge.
    task automatic tick();
        logic        hs;
        logic [63:0] e;
        @(negedge clk_i);
        cyc++;
        hs = rst_ni && s_if.req && s_if.gnt;
        if (!rst_ni || clear_i) begin
            exp_q.delete();
        end else begin
            if (s_if.r_valid && s_if.lrdy) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    chk("sb_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", {30'd0, s_if.r_user, s_if.r_data}, e);
                end
            end
            if (hs) begin
                n_hs++;
                if (s_if.wen)
                    exp_q.push_back({30'd0, s_if.user, mdat(s_if.add)});
            end
            if (m_if.req && m_if.gnt) begin
                n_iss++;
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
            end
            if (m_if.r_valid) n_mrv++;
            if (int'(reserved) > rmax) rmax = int'(reserved);
        end
        @(posedge clk_i);
        #1;
        if (hs) begin
            drv_left--;
            drv_addr += 32'd4;
        end
        start(drv_left, drv_addr, drv_wen);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int p0, i0, mv0, hb, pb;
        s_if.req = 0; s_if.add = '0; s_if.wen = 1; s_if.data = '0;
        s_if.be = '1; s_if.boffs = '0; s_if.user = '0; s_if.lrdy = 1;

        repeat (2) @(posedge clk_i);
        #3;
        chk("rst_mreq", m_if.req, 0);
        chk("rst_srv", s_if.r_valid, 0);
        chk("rst_gnt", s_if.gnt, 0);
        chk("rst_rsv", reserved, 0);
        chk("rst_flags", flags, 6'b101010);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_gnt1", s_if.gnt, 1);

        // 1: streaming reads, latency 1
        s_if.lrdy = 1; mem_lat = 1;
        p0 = n_pop; i0 = n_iss; first_iss = -1; rmax = 0;
        start(16, 32'h100, 1);
        for (int i = 0; i < 200 && n_pop - p0 < 16; i++) tick();
        repeat (3) tick();
        chk("t1_pops", n_pop - p0, 16);
        chk("t1_iss", n_iss - i0, 16);
        chk("t1_span", last_iss - first_iss, 15);
        chk("t1_rmax", rmax <= 2, 1);
        chk("t1_idle", flags.idle, 1);

        // 2: slave back-pressure, credits cap issues
        s_if.lrdy = 0;
        p0 = n_pop; i0 = n_iss;
        start(10, 32'h200, 1);
        for (int i = 0; i < 100 && drv_left > 0; i++) tick();
        repeat (10) tick();
        chk("t2_iss", n_iss - i0, 4);
        chk("t2_mreq", m_if.req, 0);
        chk("t2_rsv", reserved, 4);
        chk("t2_full", flags.rsp_full, 1);
        s_if.lrdy = 1;
        for (int i = 0; i < 200 && n_pop - p0 < 10; i++) tick();
        repeat (3) tick();
        chk("t2_pops", n_pop - p0, 10);
        chk("t2_iss2", n_iss - i0, 10);
        chk("t2_idle", flags.idle, 1);

        // 3: writes are not counted
        s_if.lrdy = 0;
        i0 = n_iss; mv0 = n_mrv; rmax = 0;
        start(8, 32'h300, 0);
        for (int i = 0; i < 100 && drv_left > 0; i++) tick();
        repeat (10) tick();
        chk("t3_iss", n_iss - i0, 8);
        chk("t3_rmax", rmax, 0);
        chk("t3_mrv", n_mrv - mv0, 0);
        chk("t3_srv", s_if.r_valid, 0);
        chk("t3_idle", flags.idle, 1);

        // 4: same-cycle counted issue and pop at reserved=3
        s_if.lrdy = 0;
        p0 = n_pop;
        start(3, 32'h400, 1);
        for (int i = 0; i < 100 && drv_left > 0; i++) tick();
        repeat (5) tick();
        chk("t4_rsv0", reserved, 3);
        start(1, 32'h410, 1);
        tick();
        chk("t4_mreq", m_if.req, 1);
        s_if.lrdy = 1;
        tick();
        s_if.lrdy = 0;
        chk("t4_rsv", reserved, 3);
        s_if.lrdy = 1;
        for (int i = 0; i < 100 && n_pop - p0 < 4; i++) tick();
        repeat (3) tick();
        chk("t4_pops", n_pop - p0, 4);
        chk("t4_rsv_end", reserved, 0);

        // 5: clear with reads in flight
        s_if.lrdy = 0; mem_lat = 4;
        i0 = n_iss; mv0 = n_mrv;
        start(2, 32'h500, 1);
        repeat (3) tick();
        chk("t5_iss", n_iss - i0, 2);
        clear_i = 1;
        tick();
        clear_i = 0;
        chk("t5_rqe", flags.req_empty, 1);
        chk("t5_rse", flags.rsp_empty, 1);
        chk("t5_rsv", reserved, 0);
        chk("t5_err0", flags.err, 0);
        for (int i = 0; i < 20 && n_mrv - mv0 < 2; i++) tick();
        repeat (2) tick();
        chk("t5_err", flags.err, 1);
        chk("t5_stored", s_if.r_valid, 1);
        repeat (5) tick();
        chk("t5_sticky", flags.err, 1);
        clear_i = 1;
        tick();
        clear_i = 0;
        chk("t5_errclr", flags.err, 0);
        chk("t5_idle", flags.idle, 1);
        mem_lat = 1;

        // 6: reset mid-burst
        s_if.lrdy = 1;
        start(6, 32'h600, 1);
        repeat (3) tick();
        rst_ni = 1'b0;
        #1;
        chk("t6_mreq", m_if.req, 0);
        chk("t6_srv", s_if.r_valid, 0);
        chk("t6_gnt", s_if.gnt, 0);
        chk("t6_rsv", reserved, 0);
        chk("t6_flags", flags, 6'b101010);
        tick();
        rst_ni = 1'b1;
        hb = n_hs; pb = n_pop;
        for (int i = 0; i < 200 && (drv_left > 0 || exp_q.size() > 0); i++)
            tick();
        repeat (3) tick();
        chk("t6_hs", n_hs - hb, 3);
        chk("t6_pops", n_pop - pb, 3);
        chk("t6_idle", flags.idle, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
